// File: rtl/psubsb_pipe.sv
// ---------------------------------------------------------------------------
// psubsb_pipe
//   Two-stage pipelined packed saturating subtractor. Each 16-bit operand
//   carries four independent 4-bit two's-complement lanes; every lane of
//   S = A - B is clamped to [-8, 7]. A valid/ready handshake is used on both
//   sides, and a saturating counter tallies delivered results in which at
//   least one lane clamped.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand pair A/B valid
//   in_ready   out  operands accepted this cycle (combinational from out_ready)
//   A          in   [15:0] minuend, lane i = A[4i+3:4i]
//   B          in   [15:0] subtrahend, same packing
//   out_valid  out  S / sat_lane valid
//   out_ready  in   downstream accepts S
//   S          out  [15:0] saturated lane differences
//   sat_lane   out  [3:0] per-lane saturation flags
//   sat_count  out  [CNT_W-1:0] count of delivered results with any saturation
//   clr_count  in   synchronous clear of sat_count (wins over an increment)
// ---------------------------------------------------------------------------
module psubsb_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      S,
    output logic [3:0]       sat_lane,
    output logic [CNT_W-1:0] sat_count,
    input  logic             clr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1: raw lane differences and operand sign bits
    logic        r_s1Valid;
    logic [15:0] r_s1Raw;
    logic [3:0]  r_s1SignA;
    logic [3:0]  r_s1SignB;

    // Stage 2: saturated result presented to the consumer
    logic        r_s2Valid;
    logic [15:0] r_s2S;
    logic [3:0]  r_s2Sat;

    logic [CNT_W-1:0] r_satCount;

    logic [15:0] w_raw;
    logic [3:0]  w_signA;
    logic [3:0]  w_signB;
    logic [15:0] w_satS;
    logic [3:0]  w_satFlag;
    logic        w_s2Load;
    logic        w_s1Advance;
    logic        w_inXfer;
    logic        w_outXfer;

    // Handshake: stage 2 can take new data when empty or being drained;
    // stage 1 then advances whenever it holds data, and can refill itself
    // whenever it is empty or advancing.
    assign w_s2Load    = ~r_s2Valid | out_ready;
    assign w_s1Advance = r_s1Valid & w_s2Load;
    assign in_ready    = ~r_s1Valid | w_s1Advance;
    assign w_inXfer    = in_valid & in_ready;
    assign w_outXfer   = r_s2Valid & out_ready;

    // Lane subtraction as A + ~B + 1, computed per 4-bit lane so no borrow
    // can leak into the neighbouring lane; the carry out is simply dropped.
    always_comb begin
        w_raw   = '0;
        w_signA = '0;
        w_signB = '0;
        for (int i = 0; i < 4; i++) begin
            w_raw[4*i +: 4] = A[4*i +: 4] + ~B[4*i +: 4] + 4'd1;
            w_signA[i]      = A[4*i + 3];
            w_signB[i]      = B[4*i + 3];
        end
    end

    // Overflow only occurs when the operand signs differ and the raw result
    // takes the sign of B; the lane is then clamped toward A's sign.
    always_comb begin
        w_satS    = r_s1Raw;
        w_satFlag = '0;
        for (int i = 0; i < 4; i++) begin
            if (!r_s1SignA[i] && r_s1SignB[i] && r_s1Raw[4*i + 3]) begin
                w_satS[4*i +: 4] = 4'b0111;
                w_satFlag[i]     = 1'b1;
            end else if (r_s1SignA[i] && !r_s1SignB[i] && !r_s1Raw[4*i + 3]) begin
                w_satS[4*i +: 4] = 4'b1000;
                w_satFlag[i]     = 1'b1;
            end
        end
    end

    // Stage 1 register: refills on every cycle it is free; a cycle without
    // in_valid loads a bubble (valid low) so nothing spurious moves forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Raw   <= '0;
            r_s1SignA <= '0;
            r_s1SignB <= '0;
        end else if (in_ready) begin
            r_s1Valid <= in_valid;
            if (w_inXfer) begin
                r_s1Raw   <= w_raw;
                r_s1SignA <= w_signA;
                r_s1SignB <= w_signB;
            end
        end
    end

    // Stage 2 register: holds S and sat_lane steady while the consumer
    // stalls; only real data overwrites the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2S     <= '0;
            r_s2Sat   <= '0;
        end else if (w_s2Load) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2S   <= w_satS;
                r_s2Sat <= w_satFlag;
            end
        end
    end

    // Saturation-event counter: counts delivered results with any lane
    // clamped, sticks at its maximum, and a clear beats a coincident count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_satCount <= '0;
        end else if (clr_count) begin
            r_satCount <= '0;
        end else if (w_outXfer && (r_s2Sat != 4'd0) && (r_satCount != CNT_MAX)) begin
            r_satCount <= r_satCount + 1'b1;
        end
    end

    assign out_valid = r_s2Valid;
    assign S         = r_s2S;
    assign sat_lane  = r_s2Sat;
    assign sat_count = r_satCount;

endmodule
